// File: rtl/code_dec_acc_pkg.sv
// Shared constants and FSM encoding for the index-to-section-mask accumulator.
package code_dec_acc_pkg;

  localparam int NUM_ELEMENTS = 14;
  localparam int IDX_W        = 4;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/code_dec.sv
// Element index to one-hot section vector (bit 0 = leftmost) plus range flag.
// Latency: combinational. Backpressure: none, pure decode.
// Out-of-range indices yield an all-zero vector with in_range low.
module code_dec
  import code_dec_acc_pkg::*;
#(
  parameter int num_elements = NUM_ELEMENTS,
  parameter int idx_width    = IDX_W
) (
  input  logic [idx_width-1:0]    index,
  output logic [0:num_elements-1] onehot,
  output logic                    in_range
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < num_elements; i++) begin
      if (index == idx_width'(i)) onehot[i] = 1'b1;
    end
  end

  assign in_range = (32'(index) < num_elements);

endmodule

// File: rtl/code_dec_acc.sv
// Accumulates set/clear index beats into a section mask; emits mask, popcount, error on last beat.
// Latency: out_valid rises one cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result is held; held until out_ready, one bubble before next group.
module code_dec_acc
  import code_dec_acc_pkg::*;
#(
  parameter int num_elements = NUM_ELEMENTS,
  parameter int idx_width    = IDX_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [idx_width-1:0]    in_index,
  input  logic                    in_op,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:num_elements-1] out_section,
  output logic [idx_width-1:0]    out_count,
  output logic                    out_err
);

  state_t                  state, state_nxt;
  logic [0:num_elements-1] mask_q, mask_nxt, onehot;
  logic                    err_q, err_nxt, in_range, accept;
  logic [idx_width-1:0]    cnt_nxt;

  code_dec #(
    .num_elements(num_elements),
    .idx_width   (idx_width)
  ) u_dec (
    .index   (in_index),
    .onehot  (onehot),
    .in_range(in_range)
  );

  assign accept = in_valid && in_ready;

  // Out-of-range beats decode to zero, so the mask update is a no-op for them.
  always_comb begin
    mask_nxt = (in_op == OP_SET) ? (mask_q | onehot) : (mask_q & ~onehot);
    err_nxt  = err_q | ~in_range;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < num_elements; i++) begin
      cnt_nxt = cnt_nxt + idx_width'(mask_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (accept && in_last) state_nxt = ST_HOLD;
      ST_HOLD:    if (out_ready)         state_nxt = ST_COLLECT;
      default:                           state_nxt = ST_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_COLLECT);
    out_valid = (state == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      err_q       <= 1'b0;
      out_section <= '0;
      out_count   <= '0;
      out_err     <= 1'b0;
    end else if (accept) begin
      mask_q <= mask_nxt;
      err_q  <= err_nxt;
      if (in_last) begin
        out_section <= mask_nxt;
        out_count   <= cnt_nxt;
        out_err     <= err_nxt;
      end
    end else if (state == ST_HOLD && out_ready) begin
      // Working state restarts for the next group once the result is taken.
      mask_q <= '0;
      err_q  <= 1'b0;
    end
  end

endmodule
